// File: rtl/counter_pkg.sv
// counter_pkg: shared BCD constants and defaults for the counter datapath
package counter_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
  localparam int DEF_DIGITS = 6;
  localparam int DEF_GAP = 16;
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcddigit.sv
// bcddigit: one BCD digit register with inc/dec chaining, clamped load and clear
//   clk, reset (async, active-low), clear, load, d (preset digit)
//   up (1 = increment), cin (count enable / carry-borrow in)
//   q (digit value), cout (carry or borrow to next digit)
module bcddigit
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             up,
  input  logic             cin,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             cout
);
  logic [BCD_W-1:0] q_nxt;
  always_comb
    q_nxt = clear ? BCD_ZERO :
            load  ? bcd_clamp(d) :
            !cin  ? q :
            up    ? (q == BCD_MAX ? BCD_ZERO : q + BCD_W'(1)) :
                    (q == BCD_ZERO ? BCD_MAX : q - BCD_W'(1));
  assign cout = cin & (up ? q == BCD_MAX : q == BCD_ZERO);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= BCD_ZERO;
    else q <= q_nxt;
endmodule

// File: rtl/bcdcount.sv
// bcdcount: BCD up/down event counter with wrap carry and rate-limited refresh trigger
//   clk, reset (async, active-low)
//   step (rising edge counts), dir (1 = up), clear, load, load_val (BCD preset)
//   cnt_out (BCD count), trigger (refresh pulse), carry (wrap pulse)
module bcdcount
  import counter_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int GAP = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  dir,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] cnt_out,
  output logic                  trigger,
  output logic                  carry
);
  localparam int GW = $clog2(GAP + 1);
  logic step_q, count, pending, serve;
  logic [GW-1:0] gap;
  logic [DIGITS:0] c;
  // clear and load win over a step edge; the discarded step is not deferred
  assign count = step & ~step_q & ~clear & ~load;
  assign serve = pending && gap == '0;
  assign c[0] = count;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcddigit u_dig (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .load (load),
      .up   (dir),
      .cin  (c[i]),
      .d    (load_val[BCD_W*i +: BCD_W]),
      .q    (cnt_out[BCD_W*i +: BCD_W]),
      .cout (c[i+1])
    );
  end
  // a change landing on the serving edge stays pending so it gets its own refresh
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      step_q  <= 1'b0;
      carry   <= 1'b0;
      trigger <= 1'b0;
      pending <= 1'b1;
      gap     <= '0;
    end else begin
      step_q  <= step;
      carry   <= c[DIGITS];
      trigger <= serve;
      pending <= clear | load | count | (pending & ~serve);
      gap     <= serve ? GW'(GAP) : gap == '0 ? gap : gap - GW'(1);
    end
endmodule
